section_serializer: RTL and testbench
=====================================

Name: section_serializer

Overview:
- Upstream feeder for the row-packing IO interface stage.
- Accepts full compressed row words with a valid-bit length from the loader over a valid/ready handshake and buffers them in a small FIFO.
- Emits each row as consecutive sectionSize-bit sections, LSB section first, with an enable strobe held high for exactly the sections of one row.
- Drops enable low for at least one cycle between rows so the packing stage closes the row on enable's falling edge.

Parameters:
- sectionSize, 4, width of one emitted section in bits; rowSize must be a multiple of it.
- rowSize, 16, width of one row word in bits.
- fifoDepth, 4, number of row entries buffered; power of two, at least 2.
- lenWidth, 5, width of the length field; must hold the value rowSize.

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-low reset.
- inData, input, rowSize, row word to serialize.
- inLen, input, lenWidth, number of valid LSBs in inData.
- inValid, input, 1, inData/inLen valid this cycle.
- inReady, output, 1, FIFO can accept this cycle.
- inputSection, output, sectionSize, current section; feeds the packer's section input.
- enable, output, 1, section valid; high for the whole row, contiguous.
- rowDone, output, 1, one-cycle pulse coincident with the last section of a row.
- busy, output, 1, FIFO non-empty or a row is in flight.

Behaviour:
- Reset (rst low at a rising edge): FIFO pointers and count go to 0; FSM goes to IDLE; inputSection=0, enable=0, rowDone=0, busy=0. inReady is 0 while rst is low.
- Reset mid-row abandons the row and all buffered entries. enable is low in the cycle after the reset edge.
- FIFO:
  - Push when inValid && inReady. inReady = !full, with no same-cycle bypass, so a full FIFO refuses input even if it pops that cycle.
  - Entry = {clampedLen, inData}. inLen > rowSize is stored as rowSize.
  - Pointers wrap modulo fifoDepth.
  - Occupancy counter runs 0..fifoDepth. Simultaneous push and pop leaves the count unchanged.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop the head into shiftReg and load remaining = ceil(len/sectionSize). If len==0, discard the entry and stay in IDLE with no enable. Otherwise go to SHIFT.
  - SHIFT:
    - enable=1; inputSection = shiftReg[sectionSize-1:0] masked so bits at index >= len (row-relative) are 0.
    - shiftReg shifts right by sectionSize each cycle and remaining decrements.
    - When remaining==1: rowDone=1 and go to GAP.
  - GAP: enable=0, inputSection=0, one cycle; then IDLE.
- Timing:
  - Latency: a word accepted at edge t into an empty, idle block is popped at edge t+1. Its first section is presented with enable high in the cycle after edge t+1.
  - Minimum per row: ceil(len/sectionSize) enable cycles + 1 GAP cycle + 1 IDLE cycle.
- inputSection and enable are registered outputs, with no combinational path from inputs.
- busy = (count!=0) || state!=IDLE.
- Masking uses the clamped length. Sections are emitted in LSB-first order, matching the packer's shift-left accumulation.

Test Plan:
- Single full row: push inData=16'hBEEF, inLen=16 into an idle block -> inputSection F,E,E,B on 4 consecutive enable cycles; rowDone with B; then enable low for ≥1 cycle; busy returns to 0.
- Partial row with upper garbage: push 16'hFFFF, inLen=10 -> exactly 3 enable cycles: F, F, 3 (last masked); rowDone on the third.
- Back-to-back/full: push 6 words on consecutive cycles (lens 16) while the first serializes -> inReady drops when 4 are stored plus 1 in flight; no word lost or duplicated; rows emitted in push order, each separated by an enable-low gap.
- Zero/over length: push len=0 then len=20 with 16'h1234 -> the first produces no enable; the second emits 4,3,2,1 (clamped to 16).
- Reset mid-row: assert rst low during the 2nd section of a 4-section row with 2 entries queued -> next cycle enable=0, inputSection=0, busy=0, FIFO empty; after release, no stale sections appear.
- Simultaneous push/pop at full: FIFO full, IDLE pops while inValid is held -> push not accepted that cycle (inReady=0); accepted the next cycle; count ends at fifoDepth.

Source files
------------

// File: rtl/section_serializer.sv
`default_nettype none
// ============================================================================
// Module   : section_serializer
// Brief    : Buffers compressed row words and emits each row as LSB-first
//            sections with a contiguous enable strobe and an inter-row gap.
// Revision : 1.0 - initial release
// ============================================================================
module section_serializer #(
    parameter int SECTION_SIZE = 4,
    parameter int ROW_SIZE     = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int LEN_WIDTH    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [ROW_SIZE-1:0]     inData,
    input  logic [LEN_WIDTH-1:0]    inLen,
    input  logic                    inValid,
    output logic                    inReady,
    output logic [SECTION_SIZE-1:0] inputSection,
    output logic                    enable,
    output logic                    rowDone,
    output logic                    busy
);

    localparam int                   c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                   c_CNT_W   = $clog2(FIFO_DEPTH + 1);
    localparam int                   c_ENTRY_W = LEN_WIDTH + ROW_SIZE;
    localparam logic [LEN_WIDTH-1:0] c_ROW_LEN = LEN_WIDTH'(ROW_SIZE);
    localparam logic [LEN_WIDTH-1:0] c_SEC_LEN = LEN_WIDTH'(SECTION_SIZE);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Row FIFO
    // ------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_CNT_W-1:0]   r_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic [LEN_WIDTH-1:0] w_clampLen;

    assign w_full     = (r_count == c_CNT_W'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    // No bypass: a full FIFO refuses input even on a popping cycle.
    assign inReady    = rst && !w_full;
    assign w_push     = inValid && inReady;
    assign w_clampLen = (inLen > c_ROW_LEN) ? c_ROW_LEN : inLen;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {w_clampLen, inData};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Head-of-FIFO decode
    // ------------------------------------------------------------------
    logic [c_ENTRY_W-1:0] w_head;
    logic [LEN_WIDTH-1:0] w_headLen;
    logic [ROW_SIZE-1:0]  w_headData;
    logic [LEN_WIDTH:0]   w_lenPlus;
    logic [LEN_WIDTH-1:0] w_headSections;

    assign w_head         = r_mem[r_rptr];
    assign w_headLen      = w_head[c_ENTRY_W-1 -: LEN_WIDTH];
    assign w_headData     = w_head[ROW_SIZE-1:0];
    assign w_lenPlus      = {1'b0, w_headLen} + (LEN_WIDTH+1)'(SECTION_SIZE - 1);
    assign w_headSections = LEN_WIDTH'(w_lenPlus / (LEN_WIDTH+1)'(SECTION_SIZE));

    // Zero every section bit at or beyond the row's valid length; bits is the
    // number of valid bits remaining from this section's LSB onward.
    function automatic logic [SECTION_SIZE-1:0] f_mask(
        input logic [SECTION_SIZE-1:0] sec,
        input logic [LEN_WIDTH-1:0]    bits
    );
        logic [SECTION_SIZE-1:0] m;
        for (int i = 0; i < SECTION_SIZE; i++) begin
            m[i] = sec[i] && (LEN_WIDTH'(i) < bits);
        end
        return m;
    endfunction

    function automatic logic [LEN_WIDTH-1:0] f_bitsAfter(
        input logic [LEN_WIDTH-1:0] bits
    );
        return (bits > c_SEC_LEN) ? (bits - c_SEC_LEN) : '0;
    endfunction

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_t                  r_state;
    logic [ROW_SIZE-1:0]     r_shift;
    logic [LEN_WIDTH-1:0]    r_remaining;
    logic [LEN_WIDTH-1:0]    r_bitsLeft;
    logic [SECTION_SIZE-1:0] r_section;
    logic                    r_enable;
    logic                    r_rowDone;

    state_t                  w_state_n;
    logic [ROW_SIZE-1:0]     w_shift_n;
    logic [LEN_WIDTH-1:0]    w_remaining_n;
    logic [LEN_WIDTH-1:0]    w_bitsLeft_n;
    logic [SECTION_SIZE-1:0] w_section_n;
    logic                    w_enable_n;
    logic                    w_rowDone_n;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_shift     <= '0;
            r_remaining <= '0;
            r_bitsLeft  <= '0;
            r_section   <= '0;
            r_enable    <= 1'b0;
            r_rowDone   <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_shift     <= w_shift_n;
            r_remaining <= w_remaining_n;
            r_bitsLeft  <= w_bitsLeft_n;
            r_section   <= w_section_n;
            r_enable    <= w_enable_n;
            r_rowDone   <= w_rowDone_n;
        end
    end

    // Outputs are registered one step ahead: r_remaining counts the sections
    // still to present including the one currently on inputSection.
    always_comb begin
        w_state_n     = r_state;
        w_shift_n     = r_shift;
        w_remaining_n = r_remaining;
        w_bitsLeft_n  = r_bitsLeft;
        w_section_n   = '0;
        w_enable_n    = 1'b0;
        w_rowDone_n   = 1'b0;
        w_pop         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_headLen != '0) begin
                        w_state_n     = S_SHIFT;
                        w_shift_n     = w_headData >> SECTION_SIZE;
                        w_remaining_n = w_headSections;
                        w_bitsLeft_n  = f_bitsAfter(w_headLen);
                        w_section_n   = f_mask(w_headData[SECTION_SIZE-1:0], w_headLen);
                        w_enable_n    = 1'b1;
                        w_rowDone_n   = (w_headSections == LEN_WIDTH'(1));
                    end
                end
            end
            S_SHIFT: begin
                if (r_remaining == LEN_WIDTH'(1)) begin
                    w_state_n = S_GAP;
                end else begin
                    w_shift_n     = r_shift >> SECTION_SIZE;
                    w_remaining_n = r_remaining - LEN_WIDTH'(1);
                    w_bitsLeft_n  = f_bitsAfter(r_bitsLeft);
                    w_section_n   = f_mask(r_shift[SECTION_SIZE-1:0], r_bitsLeft);
                    w_enable_n    = 1'b1;
                    w_rowDone_n   = (r_remaining == LEN_WIDTH'(2));
                end
            end
            S_GAP: begin
                w_state_n = S_IDLE;
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase
    end

    assign inputSection = r_section;
    assign enable       = r_enable;
    assign rowDone      = r_rowDone;
    assign busy         = !w_empty || (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_section_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_section_serializer
// Brief    : Scoreboard bench for section_serializer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_section_serializer;

    localparam int SS = 4;
    localparam int RS = 16;
    localparam int FD = 4;
    localparam int LW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [RS-1:0] inData = '0;
    logic [LW-1:0] inLen = '0;
    logic          inValid = 1'b0;
    logic          inReady;
    logic [SS-1:0] inputSection;
    logic          enable;
    logic          rowDone;
    logic          busy;

    always #5 clk = ~clk;

    section_serializer #(
        .SECTION_SIZE (SS),
        .ROW_SIZE     (RS),
        .FIFO_DEPTH   (FD),
        .LEN_WIDTH    (LW)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .inData       (inData),
        .inLen        (inLen),
        .inValid      (inValid),
        .inReady      (inReady),
        .inputSection (inputSection),
        .enable       (enable),
        .rowDone      (rowDone),
        .busy         (busy)
    );

    typedef struct packed {
        logic [SS-1:0] sec;
        logic          done;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks     = 0;
    int   n_errors     = 0;
    int   stall_cycles = 0;
    logic prev_en      = 1'b0;
    logic prev_done    = 1'b0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: clamp, zero everything above the length, then slice LSB first.
    function automatic void model_push(input logic [RS-1:0] d, input logic [LW-1:0] len);
        int            l;
        int            nsec;
        logic [RS-1:0] m;
        exp_t          e;
        l    = (int'(len) > RS) ? RS : int'(len);
        m    = (l == RS) ? d : (d & ((RS'(1) << l) - RS'(1)));
        nsec = (l + SS - 1) / SS;
        for (int i = 0; i < nsec; i++) begin
            e.sec  = m[SS*i +: SS];
            e.done = (i == nsec - 1);
            sb_q.push_back(e);
        end
    endfunction

    always @(negedge clk) begin
        if (rst && inValid && inReady) begin
            model_push(inData, inLen);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (prev_en && !prev_done) chk_eq("enable_contiguous", enable, 1);
            if (prev_done)             chk_eq("gap_after_row", enable, 0);
            if (enable) begin
                chk_eq("section_expected", (sb_q.size() != 0), 1);
                if (sb_q.size() != 0) begin
                    e = sb_q.pop_front();
                    chk_eq("section_value", inputSection, e.sec);
                    chk_eq("rowdone_value", rowDone, e.done);
                end
            end else begin
                chk_eq("idle_section_zero", inputSection, 0);
                chk_eq("idle_rowdone_zero", rowDone, 0);
            end
        end
        prev_en   <= enable;
        prev_done <= enable && rowDone;
    end

    task automatic push(input logic [RS-1:0] d, input logic [LW-1:0] len);
        int waited = 0;
        inData  = d;
        inLen   = len;
        inValid = 1'b1;
        do begin
            @(negedge clk);
            if (!inReady) begin
                stall_cycles++;
                waited++;
            end
        end while (!inReady && waited < 100);
        if (waited >= 100) chk_eq("push_timeout", waited, 0);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((busy || enable || sb_q.size() != 0) && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk_eq("drain_in_time", (c < 200), 1);
        chk_eq("scoreboard_empty", sb_q.size(), 0);
        chk_eq("busy_idle", busy, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_inready", inReady, 0);
        chk_eq("rst_enable", enable, 0);
        chk_eq("rst_section", inputSection, 0);
        chk_eq("rst_rowdone", rowDone, 0);
        chk_eq("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk_eq("ready_after_reset", inReady, 1);
        @(posedge clk);
        #1;

        // Full row with latency check
        push(16'hBEEF, 5'd16);
        @(negedge clk);
        chk_eq("lat_pop_cycle_enable", enable, 0);
        chk_eq("lat_pop_cycle_busy", busy, 1);
        @(negedge clk);
        chk_eq("lat_first_enable", enable, 1);
        chk_eq("lat_first_section", inputSection, 4'hF);
        @(posedge clk);
        #1;
        wait_idle();

        // Partial row with upper garbage
        push(16'hFFFF, 5'd10);
        wait_idle();

        // Zero length then over-length
        push(16'hABCD, 5'd0);
        push(16'h1234, 5'd20);
        wait_idle();

        // Back-to-back pushes into a filling FIFO
        stall_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            push(RS'($urandom), 5'd16);
        end
        wait_idle();
        chk_eq("backpressure_seen", (stall_cycles > 0), 1);

        // Full FIFO while the IDLE state pops: no same-cycle bypass
        for (int i = 0; i < 5; i++) begin
            push(RS'($urandom), 5'd16);
        end
        inData  = 16'hC0DE;
        inLen   = 5'd16;
        inValid = 1'b1;
        c = 0;
        do begin
            @(negedge clk);
            c++;
        end while (!(enable && rowDone) && c < 50);
        chk_eq("first_row_done_seen", (c < 50), 1);
        @(negedge clk);
        chk_eq("full_gap_ready", inReady, 0);
        @(negedge clk);
        chk_eq("full_pop_cycle_ready", inReady, 0);
        @(negedge clk);
        chk_eq("after_pop_ready", inReady, 1);
        @(posedge clk);
        #1;
        inValid = 1'b0;
        @(negedge clk);
        chk_eq("refilled_ready", inReady, 0);
        @(posedge clk);
        #1;
        wait_idle();

        // Reset during the second section with two entries queued
        push(16'h1234, 5'd16);
        push(RS'($urandom), 5'd16);
        push(RS'($urandom), 5'd16);
        rst = 1'b0;
        @(negedge clk);
        chk_eq("ready_in_reset", inReady, 0);
        @(posedge clk);
        #1;
        sb_q.delete();
        @(negedge clk);
        chk_eq("midrst_enable", enable, 0);
        chk_eq("midrst_section", inputSection, 0);
        chk_eq("midrst_rowdone", rowDone, 0);
        chk_eq("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (20) @(negedge clk);
        chk_eq("post_reset_busy", busy, 0);
        @(posedge clk);
        #1;

        // Normal operation resumes after reset
        push(16'hBEEF, 5'd16);
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
